// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths and arbiter state encoding for the wb_clk bus slice.
package wb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Pointer width for an N-entry round-robin ring; never narrower than one bit.
    function automatic int rr_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// after ptr, wrapping past N-1 back to 0. Zero output when nobody requests.
module wb_rr_picker
    import wb_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = rr_ptr_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = PTR_W'((int'(ptr_i) + off) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone classic arbiter: N_MASTERS share one slave, grant held for a whole cyc.
// Define WB_ARB_TIMEOUT_EN to add the stalled-strobe timeout that raises m_err_o.
module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_MASTERS-1:0]          m_cyc_i,
    input  logic [N_MASTERS-1:0]          m_stb_i,
    input  logic [N_MASTERS-1:0]          m_we_i,
    input  logic [N_MASTERS*WB_ADR_W-1:0] m_adr_i,
    input  logic [N_MASTERS*WB_SEL_W-1:0] m_sel_i,
    input  logic [N_MASTERS*WB_DAT_W-1:0] m_dat_i,
    output logic [WB_DAT_W-1:0]           m_dat_o,
    output logic [N_MASTERS-1:0]          m_ack_o,
    output logic [N_MASTERS-1:0]          m_err_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic                          s_we_o,
    output logic [WB_ADR_W-1:0]           s_adr_o,
    output logic [WB_SEL_W-1:0]           s_sel_o,
    output logic [WB_DAT_W-1:0]           s_dat_o,
    input  logic [WB_DAT_W-1:0]           s_dat_i,
    input  logic                          s_ack_i,
    output logic [N_MASTERS-1:0]          gnt_o
);

    localparam int PTR_W = rr_ptr_w(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_bus_arbiter: N_MASTERS must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t             state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [N_MASTERS-1:0]   pick;
    logic [PTR_W-1:0]       gidx;

    logic                   g_cyc, g_stb, g_we;
    logic [WB_ADR_W-1:0]    g_adr;
    logic [WB_SEL_W-1:0]    g_sel;
    logic [WB_DAT_W-1:0]    g_dat;
    logic                   to_fire;

    wb_rr_picker #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i (m_cyc_i),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // gnt_q is all-zero while idle, so the mux yields zeros on the slave side.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_sel = '0;
        g_dat = '0;
        gidx  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (gnt_q[k]) begin
                g_cyc = m_cyc_i[k];
                g_stb = m_stb_i[k];
                g_we  = m_we_i[k];
                g_adr = m_adr_i[k*WB_ADR_W +: WB_ADR_W];
                g_sel = m_sel_i[k*WB_SEL_W +: WB_SEL_W];
                g_dat = m_dat_i[k*WB_DAT_W +: WB_DAT_W];
                gidx  = PTR_W'(k);
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle of an unanswered strobe.
    always_comb begin
        to_fire = (state_q == ARB_BUSY) && g_stb && !s_ack_i &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d   = cnt_q + CNT_W'(1);
        if ((state_q != ARB_BUSY) || !g_stb || s_ack_i || to_fire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (|m_cyc_i) begin
                    gnt_d   = pick;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Release only when the owner drops cyc; others just wait.
                if (!g_cyc) begin
                    gnt_d   = '0;
                    state_d = ARB_IDLE;
                    ptr_d   = (gidx == PTR_W'(N_MASTERS - 1)) ? '0 : gidx + PTR_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign s_cyc_o = g_cyc;
    assign s_stb_o = g_stb & ~to_fire;
    assign s_we_o  = g_we;
    assign s_adr_o = g_adr;
    assign s_sel_o = g_sel;
    assign s_dat_o = g_dat;

    assign m_dat_o = s_dat_i;
    assign m_ack_o = gnt_q & {N_MASTERS{s_ack_i & g_stb & ~to_fire}};
    assign m_err_o = gnt_q & {N_MASTERS{to_fire}};
    assign gnt_o   = gnt_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed table, corner-case sequences,
// and randomized traffic against a grant-owner/pointer reference model.
module tb_wb_bus_arbiter;

    localparam int N  = 2;
    localparam int T  = 16;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int SW = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [N*AW-1:0]   m_adr;
    logic [N*SW-1:0]   m_sel;
    logic [N*DW-1:0]   m_dat;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o, gnt_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [SW-1:0]     s_sel_o;
    logic [DW-1:0]     s_dat_o;
    logic [DW-1:0]     s_dat;
    logic              s_ack;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owning master index (-1 = bus free), rr pointer, wait count.
    int mg, mptr, mwait;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_sel_i (m_sel),
        .m_dat_i (m_dat),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_sel_o (s_sel_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat),
        .s_ack_i (s_ack),
        .gnt_o   (gnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model for the current inputs, then advance
    // the model as the coming clock edge will.
    task automatic eval();
        logic [N-1:0] e_gnt, e_ack, e_err;
        logic         e_cyc, e_stb, e_we, fire;
        logic [AW-1:0] e_adr;
        logic [SW-1:0] e_sel;
        logic [DW-1:0] e_dat;
        e_gnt = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; fire = 1'b0;
        e_adr = '0; e_sel = '0; e_dat = '0;
        if (mg >= 0) begin
            e_gnt[mg] = 1'b1;
            e_cyc = m_cyc[mg];
            e_we  = m_we[mg];
            e_adr = m_adr[mg*AW +: AW];
            e_sel = m_sel[mg*SW +: SW];
            e_dat = m_dat[mg*DW +: DW];
            fire  = TO_EN && m_stb[mg] && !s_ack && (mwait == T - 1);
            e_stb = m_stb[mg] && !fire;
            if (s_ack && m_stb[mg] && !fire) e_ack = e_gnt;
            if (fire) e_err = e_gnt;
        end
        chk("gnt",   gnt_o,   e_gnt);
        chk("s_cyc", s_cyc_o, e_cyc);
        chk("s_stb", s_stb_o, e_stb);
        chk("s_we",  s_we_o,  e_we);
        chk("s_adr", s_adr_o, e_adr);
        chk("s_sel", s_sel_o, e_sel);
        chk("s_dat", s_dat_o, e_dat);
        chk("m_dat", m_dat_o, s_dat);
        chk("m_ack", m_ack_o, e_ack);
        chk("m_err", m_err_o, e_err);
        if (rst) begin
            mg = -1; mptr = 0; mwait = 0;
        end else begin
            if (mg >= 0 && m_stb[mg] && !s_ack && !fire) mwait++;
            else mwait = 0;
            if (mg < 0) begin
                for (int off = 0; off < N; off++) begin
                    if (mg < 0 && m_cyc[(mptr + off) % N]) mg = (mptr + off) % N;
                end
            end else if (!m_cyc[mg]) begin
                mptr = (mg + 1) % N;
                mg   = -1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                         input logic [N-1:0] we, input logic ack);
        m_cyc = cyc; m_stb = stb; m_we = we; s_ack = ack;
    endtask

    task automatic set_fixed();
        m_adr[0*AW +: AW] = 30'h0000010;  m_adr[1*AW +: AW] = 30'h0000020;
        m_sel[0*SW +: SW] = 4'hF;         m_sel[1*SW +: SW] = 4'h3;
        m_dat[0*DW +: DW] = 32'hDEADBEEF; m_dat[1*DW +: DW] = 32'h12345678;
        s_dat = 32'hCAFEF00D;
    endtask

    task automatic do_reset();
        drive('0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] cyc, stb, we;
        logic         ack;
        logic [N-1:0] e_gnt;
        logic         e_scyc;
        logic [N-1:0] e_ack;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00};
        vecs[1]  = '{2'b01, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00};
        vecs[2]  = '{2'b01, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01};
        vecs[3]  = '{2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 2'b00};
        vecs[4]  = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
        vecs[5]  = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};
        vecs[6]  = '{2'b11, 2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        vecs[7]  = '{2'b11, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 2'b10};
        vecs[8]  = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00};
        vecs[9]  = '{2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};
        vecs[10] = '{2'b01, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01};
        vecs[11] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
        vecs[12] = '{2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00};

        rst = 1'b1;
        m_adr = '0; m_sel = '0; m_dat = '0;
        drive('0, '0, '0, 1'b0);
        set_fixed();
        repeat (2) @(posedge clk);
        #1;
        mg = -1; mptr = 0; mwait = 0;
        @(negedge clk);
        chk("reset_gnt",   gnt_o,   '0);
        chk("reset_s_cyc", s_cyc_o, 1'b0);
        chk("reset_s_stb", s_stb_o, 1'b0);
        chk("reset_ack",   m_ack_o, '0);
        chk("reset_err",   m_err_o, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table from a fresh reset (pointer 0).
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].ack);
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i),   gnt_o,   vecs[i].e_gnt);
            chk($sformatf("tbl%0d_s_cyc", i), s_cyc_o, vecs[i].e_scyc);
            chk($sformatf("tbl%0d_ack", i),   m_ack_o, vecs[i].e_ack);
            if (i == 2) begin
                chk("tbl_wr_adr", s_adr_o, 30'h0000010);
                chk("tbl_wr_dat", s_dat_o, 32'hDEADBEEF);
                chk("tbl_wr_sel", s_sel_o, 4'hF);
            end
            eval();
            @(posedge clk);
            #1;
        end

        // Single-master readback: slave data reaches m_dat_o unregistered.
        do_reset();
        drive(2'b01, 2'b01, 2'b00, 1'b0);
        tick();
        s_dat = 32'hDEADBEEF; s_ack = 1'b1;
        @(negedge clk);
        chk("rd_dat", m_dat_o, 32'hDEADBEEF);
        chk("rd_ack", m_ack_o, 2'b01);
        eval();
        @(posedge clk); #1;
        drive('0, '0, '0, 1'b0);
        tick();
        set_fixed();

        // Simultaneous requests after reset, with the one-cycle dead gap on hand-off.
        do_reset();
        drive(2'b11, 2'b11, 2'b00, 1'b0);
        tick();
        chk("both_first_gnt", gnt_o, 2'b01);
        s_ack = 1'b1; tick();
        drive(2'b10, 2'b10, 2'b00, 1'b0);
        tick();
        chk("handoff_dead_gnt", gnt_o, 2'b00);
        tick();
        chk("handoff_m1_gnt", gnt_o, 2'b10);
        s_ack = 1'b1; tick();
        drive('0, '0, '0, 1'b0);
        tick();
        drive(2'b11, 2'b11, 2'b00, 1'b0);
        tick();
        chk("ptr_wrap_gnt", gnt_o, 2'b01);
        drive('0, '0, '0, 1'b0);
        tick(); tick();

        // Locked read-modify-write by m1 while m0 waits.
        do_reset();
        drive(2'b10, 2'b10, 2'b00, 1'b0);
        tick();
        chk("rmw_gnt", gnt_o, 2'b10);
        for (int s = 0; s < 3; s++) begin
            drive(2'b11, 2'b11, (s == 2) ? 2'b10 : 2'b00, 1'b1);
            @(negedge clk);
            chk("rmw_m0_ack", m_ack_o[0], 1'b0);
            chk("rmw_m1_ack", m_ack_o[1], 1'b1);
            eval();
            @(posedge clk); #1;
            drive(2'b11, 2'b01, 2'b00, 1'b0);
            tick();
            chk("rmw_hold_gnt", gnt_o, 2'b10);
        end
        drive(2'b01, 2'b01, 2'b00, 1'b0);
        tick();
        chk("rmw_release_gnt", gnt_o, 2'b00);
        tick();
        chk("rmw_m0_gnt", gnt_o, 2'b01);
        drive('0, '0, '0, 1'b0);
        tick();

        // Reset mid-strobe with pointer at 1; afterwards pointer must be back at 0.
        do_reset();
        drive(2'b01, 2'b01, 2'b00, 1'b1);
        tick(); tick();
        drive('0, '0, '0, 1'b0);
        tick();
        drive(2'b01, 2'b01, 2'b01, 1'b0);
        tick();
        chk("mid_gnt", gnt_o, 2'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_s_cyc", s_cyc_o, 1'b0);
        chk("mid_rst_s_stb", s_stb_o, 1'b0);
        chk("mid_rst_gnt",   gnt_o,   2'b00);
        drive(2'b11, 2'b11, 2'b00, 1'b0);
        tick();
        chk("mid_rst_ptr_gnt", gnt_o, 2'b01);
        drive('0, '0, '0, 1'b0);
        tick(); tick();

        // Slave never acks: err only when the timeout is built in.
        drive(2'b10, 2'b10, 2'b00, 1'b0);
        repeat (T + 6) tick();
        drive('0, '0, '0, 1'b0);
        tick(); tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!m_cyc[k]) m_cyc[k] = ($urandom % 4) == 0;
                else if (($urandom % 6) == 0) m_cyc[k] = 1'b0;
                m_stb[k] = m_cyc[k] & ($urandom % 3 != 0);
                m_we[k]  = $urandom % 2;
                m_adr[k*AW +: AW] = AW'($urandom);
                m_sel[k*SW +: SW] = SW'($urandom);
                m_dat[k*DW +: DW] = $urandom;
            end
            s_ack = ($urandom % 3) == 0;
            s_dat = $urandom;
            rst   = ($urandom % 200) == 0;
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
